// File: rtl/ram_n2t.sv
// Word-addressed register bank: one write/read port (A), one read-only port (B),
// combinational reads, optional write forwarding on port B, async whole-array clear.
module ram_n2t #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH),
  parameter bit BYPASS = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [AW-1:0]    address,
  input  logic [AW-1:0]    address_b,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_b
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_b;

  // Flop-based storage: the asynchronous clear rules out block RAM here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (load) begin
      mem[address] <= in;
    end
  end

  assign out  = mem[address];
  assign rd_b = mem[address_b];

  generate
    if (BYPASS) begin : g_fwd
      // Port B sees the pending write before the edge; port A never does.
      assign out_b = (load && (address_b == address)) ? in : rd_b;
    end else begin : g_nofwd
      assign out_b = rd_b;
    end
  endgenerate

endmodule

// File: tb/tb_ram_n2t.sv
// Self-checking bench for ram_n2t: four instances (16x8 with/without forwarding,
// 1x2 with forwarding, 32x64 without) driven from shared stimulus against array models.
module tb_ram_n2t;

  logic        clk;
  logic        reset;
  logic        load;
  logic [31:0] in_w;
  logic [5:0]  addr_w;
  logic [5:0]  addrb_w;

  logic [15:0] out0, outb0, out1, outb1;
  logic        out2, outb2;
  logic [31:0] out3, outb3;

  int checks = 0;
  int errors = 0;

  logic [15:0] m16 [8];
  logic        m2  [2];
  logic [31:0] m32 [64];

  ram_n2t #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in(in_w[15:0]), .load(load),
    .address(addr_w[2:0]), .address_b(addrb_w[2:0]), .out(out0), .out_b(outb0));
  ram_n2t #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in(in_w[15:0]), .load(load),
    .address(addr_w[2:0]), .address_b(addrb_w[2:0]), .out(out1), .out_b(outb1));
  ram_n2t #(.WIDTH(1), .DEPTH(2), .BYPASS(1'b1)) dut2 (
    .clk(clk), .reset(reset), .in(in_w[0]), .load(load),
    .address(addr_w[0]), .address_b(addrb_w[0]), .out(out2), .out_b(outb2));
  ram_n2t #(.WIDTH(32), .DEPTH(64), .BYPASS(1'b0)) dut3 (
    .clk(clk), .reset(reset), .in(in_w), .load(load),
    .address(addr_w), .address_b(addrb_w), .out(out3), .out_b(outb3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    foreach (m16[i]) m16[i] = '0;
    foreach (m2[i])  m2[i]  = 1'b0;
    foreach (m32[i]) m32[i] = '0;
  endtask

  task automatic model_write();
    m16[addr_w[2:0]] = in_w[15:0];
    m2[addr_w[0]]    = in_w[0];
    m32[addr_w]      = in_w;
  endtask

  // Compare all eight read ports with what the model says they should show now.
  task automatic check_all(input string tag);
    logic [15:0] e_b1;
    logic        e_b2;
    e_b1 = (load && addrb_w[2:0] == addr_w[2:0]) ? in_w[15:0] : m16[addrb_w[2:0]];
    e_b2 = (load && addrb_w[0] == addr_w[0]) ? in_w[0] : m2[addrb_w[0]];
    chk({tag, "_out0"},  32'(out0),  32'(m16[addr_w[2:0]]));
    chk({tag, "_outb0"}, 32'(outb0), 32'(m16[addrb_w[2:0]]));
    chk({tag, "_out1"},  32'(out1),  32'(m16[addr_w[2:0]]));
    chk({tag, "_outb1"}, 32'(outb1), 32'(e_b1));
    chk({tag, "_out2"},  32'(out2),  32'(m2[addr_w[0]]));
    chk({tag, "_outb2"}, 32'(outb2), 32'(e_b2));
    chk({tag, "_out3"},  out3,       m32[addr_w]);
    chk({tag, "_outb3"}, outb3,      m32[addrb_w]);
  endtask

  // Rising edge: update the model with what was presented, then check after it.
  task automatic step(input string tag);
    @(posedge clk);
    if (!reset && load) model_write();
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input logic l, input logic [5:0] a, input logic [5:0] ab,
                        input logic [31:0] d);
    @(negedge clk);
    load = l; addr_w = a; addrb_w = ab; in_w = d;
    #1;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; in_w = '0; addr_w = '0; addrb_w = '0;
    model_clear();
    #1;
    check_all("rst_init");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all("rst_release");

    // Fill every word, then clear asynchronously between edges.
    for (int a = 0; a < 64; a++) begin
      set_in(1'b1, 6'(a), 6'(a), 32'hBEEF_BEEF);
      step("fill");
    end
    chk("fill_word7", 32'(out0), 32'h0000_0000 | (addr_w[2:0] == 3'd7 ? 32'hBEEF : 32'h0));
    @(negedge clk);
    load = 1'b0;
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    for (int a = 0; a < 64; a++) begin
      addr_w = 6'(a); addrb_w = 6'(63 - a);
      #0.1;
      check_all("rst_clear");
    end
    chk("rst_clear_beef", 32'(out1), 32'h0);
    #0.5;
    reset = 1'b0;

    // Load gating at address 3.
    set_in(1'b1, 6'd3, 6'd3, 32'h0000_1234);
    chk("gate_pre", 32'(out0), 32'h0000);
    check_all("gate_pre");
    step("gate_wr");
    chk("gate_post", 32'(out0), 32'h1234);
    for (int n = 0; n < 2; n++) begin
      set_in(1'b0, 6'd3, 6'd3, 32'hFFFF_FFFF);
      step("gate_hold");
      chk("gate_hold_out", 32'(out0), 32'h1234);
    end

    // Dual-port independence.
    for (int k = 0; k < 8; k++) begin
      set_in(1'b1, 6'(k), 6'(k), k * 32'h0101_0101);
      step("dp_wr");
    end
    for (int k = 0; k < 8; k++) begin
      set_in(1'b0, 6'(k), 6'(7 - k), 32'h0);
      check_all("dp_rd");
      chk("dp_out",  32'(out1),  32'(k * 16'h0101));
      chk("dp_outb", 32'(outb1), 32'((7 - k) * 16'h0101));
    end

    // Forwarding vs no forwarding on a same-address write.
    set_in(1'b1, 6'd5, 6'd5, 32'h0000_00AA);
    step("fwd_seed");
    set_in(1'b1, 6'd5, 6'd5, 32'h0000_5555);
    check_all("fwd_pre");
    chk("fwd_pre_outb1", 32'(outb1), 32'h5555);
    chk("fwd_pre_out1",  32'(out1),  32'h00AA);
    chk("nofwd_pre_outb0", 32'(outb0), 32'h00AA);
    step("fwd_post");
    chk("fwd_post_outb1", 32'(outb1), 32'h5555);
    chk("nofwd_post_outb0", 32'(outb0), 32'h5555);

    // Reset held across an edge beats load.
    set_in(1'b1, 6'd2, 6'd2, 32'h7777_7777);
    reset = 1'b1;
    model_clear();
    #1;
    check_all("rprio_pre");
    step("rprio_edge");
    @(negedge clk);
    reset = 1'b0; load = 1'b0;
    #1;
    check_all("rprio_post");
    chk("rprio_mem2", 32'(out0), 32'h0);
    chk("rprio_mem2_w32", out3, 32'h0);

    // Randomised traffic with occasional asynchronous clears.
    for (int n = 0; n < 400; n++) begin
      set_in(1'($urandom_range(0, 1)), 6'($urandom), 6'($urandom_range(0, 3) == 0 ? addr_w : 6'($urandom)),
             $urandom);
      if ($urandom_range(0, 3) == 0) addrb_w = addr_w;
      #0.5;
      check_all("rnd_pre");
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b1;
        model_clear();
        #1;
        check_all("rnd_rst");
        reset = 1'b0;
      end
      step("rnd_post");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
